// File: rtl/fibonacci_checker.sv
// fibonacci_checker
// Compares a stream of observed terms against the reference Fibonacci
// sequence 1, 1, 2, 3, 5, ... (modulo 2^DATA_WIDTH). Matching terms are
// counted; the first mismatch is captured and the checker stops accepting
// terms until it is cleared or reset. Overflow of the reference sum is
// reported through a sticky wrapped flag.
module fibonacci_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   match,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] err_index,
  output logic [DATA_WIDTH-1:0]  err_value,
  output logic [COUNT_WIDTH-1:0] term_count,
  output logic                   wrapped,
  output logic [DATA_WIDTH-1:0]  expected
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // The next two reference terms; exp_prev is the one the next accepted
  // term is compared against.
  logic [DATA_WIDTH-1:0] exp_prev;
  logic [DATA_WIDTH-1:0] exp_curr;

  // One extra bit so the carry out of the reference sum is visible.
  logic [DATA_WIDTH:0]   sum_full;

  logic restart;    // reset or clear: both return everything to IDLE
  logic accept;     // a term is consumed on this edge
  logic hit;        // the presented term equals the expected value
  logic count_sat;  // term_count has reached its maximum

  assign restart   = reset | clear;
  assign sum_full  = {1'b0, exp_prev} + {1'b0, exp_curr};
  assign hit       = (in_data == exp_prev);
  assign count_sat = &term_count;
  assign expected  = exp_prev;

  // The checker refuses terms once a mismatch is latched, and during any
  // cycle in which a restart is requested so that the term is dropped.
  assign in_ready = (state != FAIL) && !restart;
  assign accept   = in_valid && in_ready;

  // Next-state decode for the IDLE / RUN / FAIL sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = hit ? RUN : FAIL;
      end
      RUN: begin
        if (accept && !hit) state_next = FAIL;
      end
      FAIL: begin
        state_next = FAIL;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; restart (reset or clear) returns to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (restart) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reference-sequence registers, counters and result flags.
  always_ff @(posedge clk) begin
    if (restart) begin
      exp_prev   <= DATA_WIDTH'(1);
      exp_curr   <= DATA_WIDTH'(1);
      term_count <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
      err_index  <= '0;
      err_value  <= '0;
      wrapped    <= 1'b0;
    end else begin
      // match is a single-cycle pulse following each accepted match.
      match <= 1'b0;
      if (accept) begin
        if (hit) begin
          exp_prev <= exp_curr;
          exp_curr <= sum_full[DATA_WIDTH-1:0];
          match    <= 1'b1;
          if (!count_sat) begin
            term_count <= term_count + COUNT_WIDTH'(1);
          end
          if (sum_full[DATA_WIDTH]) begin
            wrapped <= 1'b1;
          end
        end else begin
          // First mismatch: capture where and what. FAIL blocks further
          // acceptance, so this can only happen once per run.
          err       <= 1'b1;
          err_index <= term_count;
          err_value <= in_data;
        end
      end
    end
  end

endmodule
